// File: rtl/secp256k1_jacobian_to_affine.sv
// secp256k1 Jacobian (X,Y,Z) to affine (X/Z^2, Y/Z^3) converter, Fermat inversion.
// Optional SECP256K1_J2A_ZERO_CHECK_EN: short-circuit Z==0 and raise inf.

module secp256k1_mul_mod (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [255:0] a_i,
    input  logic [255:0] b_i,
    output logic         done_o,
    output logic [255:0] result_o
);
    localparam logic [255:0] P =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [289:0] C1 = 290'h1000003D1;
    localparam logic [257:0] C2 = 258'h1000003D1;

    logic [511:0] prod_q;
    logic         prod_v_q;
    logic [255:0] res_q;
    logic         done_q;
    logic [289:0] t1;
    logic [257:0] t2;
    logic [257:0] t3;
    logic [255:0] red;

    // 2^256 == 2^32+977 (mod p): fold the high half twice, then one final subtract
    always_comb begin
        t1  = {34'b0, prod_q[511:256]} * C1 + {34'b0, prod_q[255:0]};
        t2  = {224'b0, t1[289:256]} * C2 + {2'b0, t1[255:0]};
        t3  = t2 - {2'b0, P};
        red = (t2 >= {2'b0, P}) ? t3[255:0] : t2[255:0];
    end

    // two-stage pipe: full product, then reduction; done two cycles after start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            res_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            prod_v_q <= start_i;
            done_q   <= prod_v_q;
            if (start_i)
                prod_q <= {256'b0, a_i} * {256'b0, b_i};
            if (prod_v_q)
                res_q <= red;
        end
    end

    assign done_o   = done_q;
    assign result_o = res_q;
endmodule

module secp256k1_jacobian_to_affine (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] x_in,
    input  logic [255:0] y_in,
    input  logic [255:0] z_in,
    output logic [255:0] x_out,
    output logic [255:0] y_out,
    output logic         done,
    output logic         busy,
    output logic         inf
);
    localparam logic [255:0] EXP =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D;

    typedef enum logic [3:0] {
        IDLE, LATCH, SKIP, INV_SQR, INV_MUL, ZZ, XO, ZZZ, YO, FIN
    } state_t;

    state_t       state_q;
    logic [255:0] x_q, y_q, z_q;
    logic [255:0] acc_q, zi2_q, xr_q, yr_q;
    logic [7:0]   idx_q;
    logic         mul_start_q;
    logic [255:0] mul_a_q, mul_b_q;
    logic         mul_done;
    logic [255:0] mul_res;
    logic [255:0] x_out_q, y_out_q;
    logic         done_q, busy_q;
`ifdef SECP256K1_J2A_ZERO_CHECK_EN
    logic         inf_pend_q, inf_q;
`endif

    secp256k1_mul_mod u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (mul_start_q),
        .a_i      (mul_a_q),
        .b_i      (mul_b_q),
        .done_o   (mul_done),
        .result_o (mul_res)
    );

    // sequencer: exponentiation z^(p-2), then the four output products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            acc_q       <= '0;
            zi2_q       <= '0;
            xr_q        <= '0;
            yr_q        <= '0;
            idx_q       <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SECP256K1_J2A_ZERO_CHECK_EN
            inf_pend_q  <= 1'b0;
            inf_q       <= 1'b0;
`endif
        end else begin
            done_q      <= 1'b0;
            mul_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= x_in;
                        y_q     <= y_in;
                        z_q     <= z_in;
                        busy_q  <= 1'b1;
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    acc_q <= z_q;
                    idx_q <= 8'd254;
`ifdef SECP256K1_J2A_ZERO_CHECK_EN
                    if (z_q == '0) begin
                        xr_q       <= '0;
                        yr_q       <= '0;
                        inf_pend_q <= 1'b1;
                        state_q    <= SKIP;
                    end else begin
                        inf_pend_q  <= 1'b0;
                        mul_start_q <= 1'b1;
                        mul_a_q     <= z_q;
                        mul_b_q     <= z_q;
                        state_q     <= INV_SQR;
                    end
`else
                    mul_start_q <= 1'b1;
                    mul_a_q     <= z_q;
                    mul_b_q     <= z_q;
                    state_q     <= INV_SQR;
`endif
                end
                SKIP: state_q <= FIN;
                INV_SQR: begin
                    if (mul_done) begin
                        acc_q       <= mul_res;
                        mul_start_q <= 1'b1;
                        mul_a_q     <= mul_res;
                        if (EXP[idx_q]) begin
                            mul_b_q <= z_q;
                            state_q <= INV_MUL;
                        end else begin
                            mul_b_q <= mul_res;
                            if (idx_q == 8'd0)
                                state_q <= ZZ;
                            else
                                idx_q <= idx_q - 8'd1;
                        end
                    end
                end
                INV_MUL: begin
                    if (mul_done) begin
                        acc_q       <= mul_res;
                        mul_start_q <= 1'b1;
                        mul_a_q     <= mul_res;
                        mul_b_q     <= mul_res;
                        if (idx_q == 8'd0) begin
                            state_q <= ZZ;
                        end else begin
                            idx_q   <= idx_q - 8'd1;
                            state_q <= INV_SQR;
                        end
                    end
                end
                ZZ: begin
                    if (mul_done) begin
                        zi2_q       <= mul_res;
                        mul_start_q <= 1'b1;
                        mul_a_q     <= x_q;
                        mul_b_q     <= mul_res;
                        state_q     <= XO;
                    end
                end
                XO: begin
                    if (mul_done) begin
                        xr_q        <= mul_res;
                        mul_start_q <= 1'b1;
                        mul_a_q     <= zi2_q;
                        mul_b_q     <= acc_q;
                        state_q     <= ZZZ;
                    end
                end
                ZZZ: begin
                    if (mul_done) begin
                        mul_start_q <= 1'b1;
                        mul_a_q     <= y_q;
                        mul_b_q     <= mul_res;
                        state_q     <= YO;
                    end
                end
                YO: begin
                    if (mul_done) begin
                        yr_q    <= mul_res;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    x_out_q <= xr_q;
                    y_out_q <= yr_q;
`ifdef SECP256K1_J2A_ZERO_CHECK_EN
                    inf_q   <= inf_pend_q;
`endif
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x_out = x_out_q;
    assign y_out = y_out_q;
    assign done  = done_q;
    assign busy  = busy_q;
`ifdef SECP256K1_J2A_ZERO_CHECK_EN
    assign inf   = inf_q;
`else
    assign inf   = 1'b0;
`endif
endmodule

// File: tb/tb_secp256k1_jacobian_to_affine.sv
// Scoreboard bench for secp256k1_jacobian_to_affine.
// Directed curve points; expectations queued at issue, checked on done.

module tb_secp256k1_jacobian_to_affine;
    localparam logic [255:0] P =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] GX =
        256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY =
        256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] G2X =
        256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] G2Y =
        256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    // multiplier latency Lm = 2 -> 507*(2+1)+2
    localparam int LAT_FULL = 1523;
`ifdef SECP256K1_J2A_ZERO_CHECK_EN
    localparam int       LAT_Z0 = 3;
    localparam logic     INF_Z0 = 1'b1;
`else
    localparam int       LAT_Z0 = LAT_FULL;
    localparam logic     INF_Z0 = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] x_in = '0, y_in = '0, z_in = '0;
    logic [255:0] x_out, y_out;
    logic         done, busy, inf;

    secp256k1_jacobian_to_affine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .z_in  (z_in),
        .x_out (x_out),
        .y_out (y_out),
        .done  (done),
        .busy  (busy),
        .inf   (inf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] x;
        logic [255:0] y;
        logic         inf;
        int           lat;
        int           acc;
        int           id;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id,
                       input logic [255:0] act, input logic [255:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %h want %h", nm, id, act, want);
        end
    endtask

    function automatic logic [255:0] mulm(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = ({256'b0, a} * {256'b0, b}) % {256'b0, P};
        return t[255:0];
    endfunction

    function automatic logic [255:0] addm(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= {1'b0, P}) t = t - {1'b0, P};
        return t[255:0];
    endfunction

    function automatic logic [255:0] subm(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] t;
        if (a >= b) t = {1'b0, a} - {1'b0, b};
        else t = {1'b0, a} + {1'b0, P} - {1'b0, b};
        return t[255:0];
    endfunction

    // monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (prev_done)
            chk("done_width", -1, {255'b0, done}, 256'd0);
        prev_done = done;
        if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", -1, 256'd1, 256'd0);
            end else begin
                e = sb_q.pop_front();
                chk("x_out", e.id, x_out, e.x);
                chk("y_out", e.id, y_out, e.y);
                chk("inf", e.id, {255'b0, inf}, {255'b0, e.inf});
                chk("latency", e.id, 256'(cyc - e.acc), 256'(e.lat));
            end
        end
    end

    task automatic apply(input int id,
                         input logic [255:0] xi, input logic [255:0] yi,
                         input logic [255:0] zi,
                         input logic [255:0] ex, input logic [255:0] ey,
                         input logic ei, input int lat, output int c0);
        exp_t n;
        @(negedge clk);
        x_in  = xi;
        y_in  = yi;
        z_in  = zi;
        start = 1'b1;
        c0    = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        n.x = ex; n.y = ey; n.inf = ei;
        n.lat = lat; n.acc = cyc; n.id = id;
        sb_q.push_back(n);
    endtask

    task automatic wait_done(input int id, input int c0);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge clk);
            #1;
            got = (done_cnt != c0);
        end
        chk("done_timeout", id, {255'b0, got}, 256'd1);
    endtask

    initial begin
        int c0;
        logic [255:0] yy, s, m, x3, y3, z3;
        bit got;

        repeat (3) @(negedge clk);
        chk("rst_x", 0, x_out, '0);
        chk("rst_y", 0, y_out, '0);
        chk("rst_done", 0, {255'b0, done}, '0);
        chk("rst_busy", 0, {255'b0, busy}, '0);
        chk("rst_inf", 0, {255'b0, inf}, '0);
        rst_n = 1'b1;

        // identity Z=1
        apply(1, GX, GY, 256'd1, GX, GY, 1'b0, LAT_FULL, c0);
        chk("busy_after_accept", 1, {255'b0, busy}, 256'd1);
        wait_done(1, c0);

        // scaled Z=2
        apply(2, mulm(GX, 256'd4), mulm(GY, 256'd8), 256'd2,
              GX, GY, 1'b0, LAT_FULL, c0);
        wait_done(2, c0);

        // Z = p-1, Y negated
        apply(3, GX, P - GY, P - 256'd1, GX, GY, 1'b0, LAT_FULL, c0);
        wait_done(3, c0);

        // Jacobian doubling of G (a=0)
        yy = mulm(GY, GY);
        s  = mulm(256'd4, mulm(GX, yy));
        m  = mulm(256'd3, mulm(GX, GX));
        x3 = subm(mulm(m, m), addm(s, s));
        y3 = subm(mulm(m, subm(s, x3)), mulm(256'd8, mulm(yy, yy)));
        z3 = addm(GY, GY);
        apply(4, x3, y3, z3, G2X, G2Y, 1'b0, LAT_FULL, c0);
        wait_done(4, c0);

        // point at infinity
        apply(5, GX, GY, 256'd0, 256'd0, 256'd0, INF_Z0, LAT_Z0, c0);
        wait_done(5, c0);

        // start hammered while busy, inputs scrambled mid-run
        apply(6, GX, GY, 256'd1, GX, GY, 1'b0, LAT_FULL, c0);
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt != c0) begin
                start = 1'b0;
                got = 1'b1;
            end else begin
                start = busy;
                x_in  = {8{$urandom()}};
                y_in  = {8{$urandom()}};
                z_in  = {8{$urandom()}};
            end
        end
        start = 1'b0;
        chk("done_timeout", 6, {255'b0, got}, 256'd1);
        repeat (20) @(negedge clk);
        chk("single_done", 6, 256'(done_cnt - c0), 256'd1);

        // reset mid-inversion
        apply(7, GX, GY, 256'd1, GX, GY, 1'b0, LAT_FULL, c0);
        repeat (900) @(negedge clk);
        chk("busy_mid_run", 7, {255'b0, busy}, 256'd1);
        rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        chk("mid_rst_x", 7, x_out, '0);
        chk("mid_rst_y", 7, y_out, '0);
        chk("mid_rst_busy", 7, {255'b0, busy}, '0);
        chk("mid_rst_done", 7, {255'b0, done}, '0);
        chk("mid_rst_inf", 7, {255'b0, inf}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        apply(8, GX, GY, 256'd1, GX, GY, 1'b0, LAT_FULL, c0);
        wait_done(8, c0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 9, 256'(sb_q.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/secp256k1_jacobian_to_affine.md
# secp256k1_jacobian_to_affine

Converts a secp256k1 point from Jacobian (X, Y, Z) to affine (x, y) = (X·Z⁻², Y·Z⁻³) mod p. It sits at the output of the point-add/point-double datapath and produces the affine coordinates required for serialization, comparison and hashing. Z⁻¹ is computed by Fermat inversion, Z^(p−2), using MSB-first square-and-multiply on a single shared `secp256k1_mul_mod` instance. No other arithmetic unit is used.

## Interface
- No parameters; p = 2^256 − 2^32 − 977 and exponent E = p − 2 = 0xFFFF…FFFE_FFFFFC2D are fixed constants.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- x_in, y_in, z_in  in  256 each  Jacobian input; each < p; latched on accepted start.
- x_out, y_out  out  256 each  affine result; valid when done=1, held until next done.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after an accepted start until done.
- inf  out  1  point at infinity (Z=0) flag; qualified by done; held with x_out/y_out.

## Operation
- Multiplier handshake: assert mul_start for exactly one cycle with mul_a/mul_b stable; wait for mul_done; capture mul_result on that cycle. Issue the next operation on the same edge. At most one multiplication is outstanding.
- States and transitions:
  - IDLE → LATCH on start.
  - LATCH: acc ← z_in; bit index i ← 254; phase ← SQR.
  - INV_SQR: acc ← acc². If E[i]=1 → INV_MUL. Otherwise i decrements; → INV_SQR, or → ZZ once i has passed 0.
  - INV_MUL: acc ← acc·z. Same i-decrement and exit rule as INV_SQR.
  - ZZ: zi2 ← acc²
  - XO: x_out ← x·zi2
  - ZZZ: zi3 ← zi2·acc
  - YO: y_out ← y·zi3
  - DONE: done=1 → IDLE.
- Multiplication count: bit 255 of E is skipped, since acc starts at z. This gives 255 squarings + 248 multiplies (popcount(E)=249) + 4 output operations = 507 total.
- Bit index: 8-bit down-counter; inversion terminates after the operation at i=0.
- start while busy is ignored; no queueing. Inputs are sampled only in IDLE.
- Reset, at any time including mid-operation:
  - state → IDLE
  - x_out, y_out → 0; done, busy, inf, mul_start → 0
  - An in-flight multiplier result is discarded. The multiplier shares rst_n.

## Timing
- Let Lm = cycles from mul_start high to mul_done high.
- Latency from the start-accept edge to done high: 507·(Lm+1) + 2 cycles.
- done is high for exactly one cycle. busy falls on the same edge that done rises.
- A new start is accepted in the cycle after done (IDLE). Back-to-back gap is 1 cycle.
- x_out/y_out/inf update only on the done edge; they are stable at all other times.

## Configuration
- SECP256K1_J2A_ZERO_CHECK_EN defined:
  - LATCH tests z_in == 0.
  - If zero: skip all multiplications; x_out=y_out=0, inf=1, done pulses 3 cycles after the start-accept edge.
  - For nonzero Z, inf=0.
- Not defined:
  - No comparator; inf is tied to 0.
  - Z=0 runs the full 507-operation sequence and yields x_out=y_out=0, since 0^(p−2)=0.

## Test plan
- Identity: X=Gx=79BE667E…16F81798, Y=Gy=483ADA77…FB10D4B8, Z=1 → x_out=Gx, y_out=Gy, inf=0, done exactly 507·(Lm+1)+2 cycles after start.
- Scaled G: Z=2, X=4·Gx mod p, Y=8·Gy mod p → x_out=Gx, y_out=Gy. Also Z=p−1 with X=Gx, Y=p−Gy → Gx, Gy.
- Doubling chain: feed the point-double Jacobian output for 2G → x_out=C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5.
- Z=0: with macro → inf=1, outputs 0, done at +3 cycles. Without macro → outputs 0, inf=0, full latency.
- Protocol:
  - start pulsed every cycle while busy → exactly one done; outputs match the first latched inputs.
  - Inputs changed mid-run → result unaffected.
- Reset: deassert rst_n mid-INV_SQR (i≈100) → all outputs 0 immediately. A restart with Z=1 input then completes correctly with full latency.
